// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the iterative AES-128 decryption sequencer.
// Optional abort support is selected by AES_DEC_CTRL_ABORT_EN in aes_dec_ctrl.
package aes_dec_pkg;

  localparam int AES128_NUM_ROUNDS = 10;
  localparam int KEY_IDX_W         = 4;
  localparam int NUM_KEYS          = AES128_NUM_ROUNDS + 1;

  localparam logic [KEY_IDX_W-1:0] LAST_KEY_IDX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } dec_state_e;

  function automatic logic key_idx_valid(input logic [KEY_IDX_W-1:0] idx);
    return (idx <= LAST_KEY_IDX);
  endfunction

endpackage

// File: rtl/aes_dec_ctrl_if.sv
// Block stream, key load and round-datapath signals of aes_dec_ctrl.
// slave = controller side, master = surrounding environment.
interface aes_dec_ctrl_if;
  import aes_dec_pkg::*;

  logic                 key_wr_en;
  logic [KEY_IDX_W-1:0] key_wr_idx;
  logic [127:0]         key_wr_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;
  logic [127:0]         round_in_data;
  logic [127:0]         round_in_key;
  logic                 round_last;
  logic [127:0]         round_out_data;
  logic                 busy;
  logic [3:0]           round_cnt;

  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_data, in_valid, in_data, out_ready, round_out_data,
    output in_ready, out_valid, out_data, round_in_data, round_in_key, round_last, busy, round_cnt
  );

  modport master (
    output key_wr_en, key_wr_idx, key_wr_data, in_valid, in_data, out_ready, round_out_data,
    input  in_ready, out_valid, out_data, round_in_data, round_in_key, round_last, busy, round_cnt
  );

endinterface

// File: rtl/aes_dec_key_store.sv
// Eleven-entry AES-128 round-key register file: one synchronous write port,
// one combinational indexed read port, plus a fixed tap on the last key.
module aes_dec_key_store
  import aes_dec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [KEY_IDX_W-1:0] wr_idx_i,
  input  logic [127:0]         wr_data_i,
  input  logic [KEY_IDX_W-1:0] rd_idx_i,
  output logic [127:0]         rd_key_o,
  output logic [127:0]         last_key_o
);

  logic [127:0] keys_q [0:NUM_KEYS-1];

  // Key registers; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        keys_q[i] <= 128'd0;
      end
    end else if (wr_en_i && key_idx_valid(wr_idx_i)) begin
      keys_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Indexed read port.
  always_comb begin
    rd_key_o = 128'd0;
    if (key_idx_valid(rd_idx_i)) begin
      rd_key_o = keys_q[rd_idx_i];
    end else begin
      rd_key_o = 128'd0;
    end
  end

  // The initial whitening key is needed in IDLE while the read port shows K9.
  assign last_key_o = keys_q[LAST_KEY_IDX];

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption sequencer driving an external single-round datapath.
// Define AES_DEC_CTRL_ABORT_EN to add the abort_i port.
module aes_dec_ctrl
  import aes_dec_pkg::*;
#(
  parameter int ROUND_LAT = 1
) (
  input logic clk,
  input logic rst,
`ifdef AES_DEC_CTRL_ABORT_EN
  input logic abort_i,
`endif
  aes_dec_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_LAST  = 4'(ROUND_LAT - 1);
  localparam logic [3:0] LAST_ROUND = 4'(AES128_NUM_ROUNDS);

  dec_state_e           state_q;
  logic [3:0]           round_cnt_q;
  logic [3:0]           wait_q;
  logic [127:0]         data_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 round_last_q;
  logic                 abort_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 key_wr_s;
  logic [KEY_IDX_W-1:0] rd_idx_s;
  logic [127:0]         rd_key_s;
  logic [127:0]         last_key_s;

`ifdef AES_DEC_CTRL_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // Input acceptance and round-key selection; key reads outside ROUND park on K9.
  always_comb begin
    in_ready_s = 1'b0;
    rd_idx_s   = LAST_KEY_IDX - 4'd1;
    if (!rst && (state_q == ST_IDLE) && !bus.key_wr_en) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    if (state_q == ST_ROUND) begin
      rd_idx_s = LAST_KEY_IDX - round_cnt_q;
    end else begin
      rd_idx_s = LAST_KEY_IDX - 4'd1;
    end
  end

  assign accept_s = in_ready_s & bus.in_valid;
  assign key_wr_s = bus.key_wr_en & (state_q == ST_IDLE);

  aes_dec_key_store u_key_store (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (key_wr_s),
    .wr_idx_i   (bus.key_wr_idx),
    .wr_data_i  (bus.key_wr_data),
    .rd_idx_i   (rd_idx_s),
    .rd_key_o   (rd_key_s),
    .last_key_o (last_key_s)
  );

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      round_cnt_q  <= 4'd0;
      wait_q       <= 4'd0;
      data_q       <= 128'd0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      round_last_q <= 1'b0;
    end else if (abort_s && (state_q != ST_IDLE)) begin
      // The state register is deliberately kept; only control returns to IDLE.
      state_q      <= ST_IDLE;
      round_cnt_q  <= 4'd0;
      wait_q       <= 4'd0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      round_last_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            data_q       <= bus.in_data ^ last_key_s;
            round_cnt_q  <= 4'd1;
            wait_q       <= 4'd0;
            busy_q       <= 1'b1;
            round_last_q <= 1'b0;
            state_q      <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (wait_q == WAIT_LAST) begin
            data_q <= bus.round_out_data;
            wait_q <= 4'd0;
            if (round_cnt_q == LAST_ROUND) begin
              state_q      <= ST_DONE;
              out_valid_q  <= 1'b1;
              round_last_q <= 1'b0;
            end else begin
              round_cnt_q  <= round_cnt_q + 4'd1;
              round_last_q <= (round_cnt_q == (LAST_ROUND - 4'd1));
            end
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            round_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          round_cnt_q  <= 4'd0;
          wait_q       <= 4'd0;
          out_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          round_last_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = data_q;
  assign bus.round_in_data = data_q;
  assign bus.round_in_key  = rd_key_s;
  assign bus.round_last    = round_last_q;
  assign bus.busy          = busy_q;
  assign bus.round_cnt     = round_cnt_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: two instances (ROUND_LAT 1 and 3) with a behavioural
// AES inverse-round datapath and a whole-block decryption reference model.
module tb_aes_dec_ctrl;

  localparam int S_RDY  = 0;
  localparam int S_OV   = 1;
  localparam int S_OD   = 2;
  localparam int S_BUSY = 3;
  localparam int S_CNT  = 4;
  localparam int S_RID  = 5;
  localparam int S_RIK  = 6;
  localparam int S_LAST = 7;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_dec_ctrl_if if0 ();
  aes_dec_ctrl_if if1 ();

`ifdef AES_DEC_CTRL_ABORT_EN
  logic tb_abort;
  aes_dec_ctrl #(.ROUND_LAT(1)) dut0 (.clk(clk), .rst(rst), .abort_i(tb_abort), .bus(if0));
  aes_dec_ctrl #(.ROUND_LAT(3)) dut1 (.clk(clk), .rst(rst), .abort_i(tb_abort), .bus(if1));
`else
  aes_dec_ctrl #(.ROUND_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  aes_dec_ctrl #(.ROUND_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]   inv_sbox [0:255];
  logic [127:0] mk  [0:10];
  logic [127:0] c1k [0:10];
  logic [127:0] p1_q, p2_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // One FIPS-197 inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last.
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] key, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) b[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[rr + 4*((c + rr) % 4)] = inv_sbox[b[rr + 4*c]];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    r = r ^ key;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = r[127-32*c -: 8];
        a1 = r[119-32*c -: 8];
        a2 = r[111-32*c -: 8];
        a3 = r[103-32*c -: 8];
        r[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
        r[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
        r[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
        r[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ mk[10];
    for (int r = 1; r <= 10; r++) s = inv_round(s, mk[10-r], r == 10);
    return s;
  endfunction

  assign if0.round_out_data = inv_round(if0.round_in_data, if0.round_in_key, if0.round_last);

  always_ff @(posedge clk) begin
    p1_q <= inv_round(if1.round_in_data, if1.round_in_key, if1.round_last);
    p2_q <= p1_q;
  end
  assign if1.round_out_data = p2_q;

  function automatic logic [127:0] obs(input int d, input int sel);
    logic [127:0] v;
    v = 128'd0;
    case (sel)
      S_RDY:   v = (d == 0) ? 128'(if0.in_ready)      : 128'(if1.in_ready);
      S_OV:    v = (d == 0) ? 128'(if0.out_valid)     : 128'(if1.out_valid);
      S_OD:    v = (d == 0) ? if0.out_data            : if1.out_data;
      S_BUSY:  v = (d == 0) ? 128'(if0.busy)          : 128'(if1.busy);
      S_CNT:   v = (d == 0) ? 128'(if0.round_cnt)     : 128'(if1.round_cnt);
      S_RID:   v = (d == 0) ? if0.round_in_data       : if1.round_in_data;
      S_RIK:   v = (d == 0) ? if0.round_in_key        : if1.round_in_key;
      S_LAST:  v = (d == 0) ? 128'(if0.round_last)    : 128'(if1.round_last);
      default: v = 128'd0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic key_write(input int mask, input logic [3:0] idx, input logic [127:0] data, input bit stored);
    if0.key_wr_en = mask[0];
    if1.key_wr_en = mask[1];
    if0.key_wr_idx = idx;  if1.key_wr_idx = idx;
    if0.key_wr_data = data; if1.key_wr_data = data;
    #1;
    if (mask[0]) chk("in_ready_during_key_wr_0", obs(0, S_RDY), 128'd0);
    if (mask[1]) chk("in_ready_during_key_wr_1", obs(1, S_RDY), 128'd0);
    @(negedge clk);
    if0.key_wr_en = 1'b0;
    if1.key_wr_en = 1'b0;
    if (stored) mk[idx] = data;
  endtask

  // action: 0 plain, 1 key write while busy, 2 rst at round 5, 3 abort at round 4.
  task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] exp_pt,
                           input int stall, input int action);
    int lat;
    int rnd;
    logic [127:0] st [0:10];
    lat = (d == 0) ? 1 : 3;
    st[0] = ct ^ mk[10];
    for (int r = 1; r <= 10; r++) st[r] = inv_round(st[r-1], mk[10-r], r == 10);
    if0.in_data = ct; if1.in_data = ct;
    if0.in_valid = (d == 0); if1.in_valid = (d == 1);
    #1;
    chk("in_ready_before_accept", obs(d, S_RDY), 128'd1);
    @(posedge clk);
    @(negedge clk);
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    for (int k = 0; k < 10*lat; k++) begin
      rnd = k / lat + 1;
      if0.key_wr_en = 1'b0; if1.key_wr_en = 1'b0;
      chk("round_cnt", obs(d, S_CNT), 128'(rnd));
      chk("round_in_key", obs(d, S_RIK), mk[10-rnd]);
      chk("round_in_data", obs(d, S_RID), st[rnd-1]);
      chk("round_last", obs(d, S_LAST), 128'(rnd == 10));
      chk("out_valid_early", obs(d, S_OV), 128'd0);
      chk("busy_in_round", obs(d, S_BUSY), 128'd1);
      if (action == 1 && k == 2) begin
        if (d == 0) if0.key_wr_en = 1'b1; else if1.key_wr_en = 1'b1;
        if0.key_wr_idx = 4'd10; if1.key_wr_idx = 4'd10;
        if0.key_wr_data = {$urandom, $urandom, $urandom, $urandom};
        if1.key_wr_data = if0.key_wr_data;
      end
      if (action == 2 && k == 4*lat) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", obs(d, S_BUSY), 128'd0);
        chk("rst_round_cnt", obs(d, S_CNT), 128'd0);
        chk("rst_out_valid", obs(d, S_OV), 128'd0);
        chk("rst_in_ready", obs(d, S_RDY), 128'd0);
        chk("rst_key9_cleared", obs(d, S_RIK), 128'd0);
        chk("rst_state_cleared", obs(d, S_RID), 128'd0);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) mk[i] = 128'd0;
        repeat (15) begin
          @(negedge clk);
          chk("no_output_after_rst", obs(d, S_OV), 128'd0);
        end
        return;
      end
`ifdef AES_DEC_CTRL_ABORT_EN
      if (action == 3 && k == 3*lat) begin
        tb_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_abort = 1'b0;
        chk("abort_busy", obs(d, S_BUSY), 128'd0);
        chk("abort_round_cnt", obs(d, S_CNT), 128'd0);
        chk("abort_out_valid", obs(d, S_OV), 128'd0);
        chk("abort_round_last", obs(d, S_LAST), 128'd0);
        chk("abort_state_kept", obs(d, S_RID), st[rnd-1]);
        chk("abort_in_ready", obs(d, S_RDY), 128'd1);
        chk("abort_idle_other_busy", obs(1-d, S_BUSY), 128'd0);
        chk("abort_idle_other_ready", obs(1-d, S_RDY), 128'd1);
        repeat (12) begin
          @(negedge clk);
          chk("no_output_after_abort", obs(d, S_OV), 128'd0);
        end
        return;
      end
`endif
      @(negedge clk);
    end
    if0.key_wr_en = 1'b0; if1.key_wr_en = 1'b0;
    chk("out_valid_rise", obs(d, S_OV), 128'd1);
    chk("out_data", obs(d, S_OD), exp_pt);
    chk("in_ready_in_done", obs(d, S_RDY), 128'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", obs(d, S_OV), 128'd1);
      chk("stall_out_data", obs(d, S_OD), exp_pt);
      chk("stall_in_ready", obs(d, S_RDY), 128'd0);
    end
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.out_ready = 1'b0; if1.out_ready = 1'b0;
    chk("post_hs_out_valid", obs(d, S_OV), 128'd0);
    chk("post_hs_in_ready", obs(d, S_RDY), 128'd1);
    chk("post_hs_busy", obs(d, S_BUSY), 128'd0);
    chk("post_hs_round_cnt", obs(d, S_CNT), 128'd0);
  endtask

  initial begin
    logic [127:0] ct;
    // Inverse S-box derived from GF(2^8) inversion and the forward affine map.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      inv_sbox[s] = 8'(x);
    end
    c1k[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    c1k[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    c1k[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    c1k[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    c1k[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    c1k[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    c1k[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    c1k[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    c1k[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    c1k[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    c1k[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 0; i <= 10; i++) mk[i] = 128'd0;

    rst = 1'b1;
`ifdef AES_DEC_CTRL_ABORT_EN
    tb_abort = 1'b0;
`endif
    if0.key_wr_en = 1'b0; if0.key_wr_idx = 4'd0; if0.key_wr_data = 128'd0;
    if1.key_wr_en = 1'b0; if1.key_wr_idx = 4'd0; if1.key_wr_data = 128'd0;
    if0.in_valid = 1'b0; if0.in_data = 128'd0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = 128'd0; if1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("in_ready_in_rst", obs(d, S_RDY), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_out_valid", obs(d, S_OV), 128'd0);
      chk("reset_out_data", obs(d, S_OD), 128'd0);
      chk("reset_round_last", obs(d, S_LAST), 128'd0);
      chk("reset_busy", obs(d, S_BUSY), 128'd0);
      chk("reset_round_cnt", obs(d, S_CNT), 128'd0);
      chk("reset_in_ready", obs(d, S_RDY), 128'd1);
      chk("reset_round_in_key", obs(d, S_RIK), 128'd0);
      chk("reset_round_in_data", obs(d, S_RID), 128'd0);
    end

    for (int i = 0; i <= 10; i++) key_write(3, 4'(i), c1k[i], 1'b1);
    run_block(0, C1_CT, C1_PT, 0, 0);
    run_block(0, C1_CT, C1_PT, 5, 1);
    key_write(3, 4'd12, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    run_block(0, C1_CT, C1_PT, 0, 0);
    run_block(1, C1_CT, C1_PT, 0, 0);

    for (int i = 0; i <= 10; i++) key_write(3, 4'(i), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    for (int n = 0; n < 4; n++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      run_block(n % 2, ct, model_dec(ct), int'($urandom_range(0, 3)), 0);
    end

    for (int i = 0; i <= 10; i++) key_write(3, 4'(i), c1k[i], 1'b1);
    run_block(0, C1_CT, C1_PT, 0, 2);
    for (int i = 0; i <= 10; i++) key_write(3, 4'(i), c1k[i], 1'b1);
    run_block(0, C1_CT, C1_PT, 0, 0);

`ifdef AES_DEC_CTRL_ABORT_EN
    run_block(0, C1_CT, C1_PT, 0, 3);
    run_block(0, C1_CT, C1_PT, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
